pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised N-stage in-order pipeline skeleton: per-stage valid + payload registers with
//  valid/allowin/ready_go handshake, per-stage stall, and branch-style flush of younger stages.
//  Replaces the free-running one-hot stage counter in the CPU top. Each stage's decode/ALU/mem
//  logic hangs off stage_data/stage_valid and drives stage_ready_go and flush_req.
// PARAMETERS
//  STAGES  5   number of pipeline stages, >=2; index 0 = youngest (IF->ID), STAGES-1 = oldest (WB)
//  DW      64  payload bits carried per stage (e.g. {pc, inst})
// PORTS
//  clk             in   1            rising-edge clock
//  resetn          in   1            asynchronous active-low reset
//  in_valid        in   1            upstream payload valid
//  in_ready        out  1            upstream accept; accepted when in_valid & in_ready
//  in_data         in   DW           upstream payload
//  stage_ready_go  in   STAGES       bit i: stage i has finished its work this cycle
//  flush_req       in   STAGES       bit k: stage k redirects; kill all stages younger than k
//  stage_valid     out  STAGES       bit i: stage i holds a live entry
//  stage_data      out  STAGES*DW    payload of stage i at [i*DW +: DW]
//  out_valid       out  1            oldest stage retires this cycle
//  out_data        out  DW           payload of the oldest stage
//  out_ready       in   1            downstream accepts the retiring entry
//  perf_stall_cnt  out  32           (PIPE_PERF_CNT_EN only) see CONFIGURATION
//  perf_flush_cnt  out  32           (PIPE_PERF_CNT_EN only) see CONFIGURATION
// BEHAVIOUR
//  - Reset (resetn=0, async): all stage_valid=0, all stage_data=0, counters=0.
//    Outputs settle combinationally: in_ready=1, out_valid=0.
//  - allowin[STAGES]=out_ready; allowin[i]=~valid[i] | (stage_ready_go[i] & allowin[i+1]).
//  - to_next[i]=valid[i] & stage_ready_go[i]; to_next[-1]=in_valid.
//  - in_ready=allowin[0]; out_valid=to_next[STAGES-1]; out_data=data[STAGES-1].
//  - kill[j]=|flush_req[STAGES-1:j+1]; kill[-1]=|flush_req.
//  - Per cycle, stage j:
//    - if allowin[j]: valid[j]<=to_next[j-1] & ~kill[j-1]; data[j]<=data[j-1] when to_next[j-1]
//      (in_data for j=0), else data holds.
//    - else: valid[j]<=valid[j] & ~kill[j], data holds.
//  - The flushing stage itself is not killed; it advances or holds normally.
//  - Input accepted during a flush is consumed (in_ready unaffected) and discarded.
//  - Latency: accept -> out_valid after STAGES cycles with all ready_go=1 and out_ready=1.
//    Full throughput is 1 entry/cycle. No bubbles are inserted except by stalls.
//  - Stall: stage i with ready_go=0 holds. Stages < i back up only as they fill. Stages > i drain.
//  - Simultaneous flush_req bits: the oldest flusher dominates (union of kills).
//  - A flush from stage k while stage k stalls still kills stages <k in that cycle.
//  - Reset asserted mid-operation clears every entry immediately, with no retirement.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    - perf_stall_cnt increments each cycle with in_valid & ~in_ready.
//    - perf_flush_cnt adds the number of live entries killed that cycle (popcount).
//    - Both wrap modulo 2^32.
//  Undefined: both ports and counters are absent; no other behaviour changes.
// STRUCTURE
//  pipe_pkg:
//    - stage index constants IF=0, ID=1, EX=2, MEM=3, WB=4
//    - default DW
//    - payload field offsets PC_LSB/INST_LSB
//  Sub-module pipe_stage_reg: one valid bit + DW payload register with async reset.
//    Inputs are allowin, prev to_next, kill_in, kill_self. It is instantiated STAGES times in a generate loop.
//    Top level holds the allowin/kill chains, I/O mapping, and optional counters.
// TESTING
//  1. Stream 0x1..0x8 with all ready_go=1 and out_ready=1 -> out_data 0x1..0x8 on consecutive
//     cycles, first out_valid 5 cycles after the first accept.
//  2. Hold stage_ready_go[2]=0 for 3 cycles with a full pipe -> stages 0-2 freeze, in_ready=0,
//     one bubble reaches stage 3. Release -> the sequence resumes intact; perf_stall_cnt=3.
//  3. flush_req[2] one cycle with a full pipe -> stages 0,1 and the input entry are killed;
//     stage 2 retires next. perf_flush_cnt += 3 (2 stages + accepted input).
//  4. flush_req[1] and flush_req[3] together -> stages 0-2 and the input are killed, stage 3 survives.
//  5. out_ready=0 for 4 cycles -> the pipe fills to 5 entries and then in_ready=0.
//     No entry is lost or duplicated.
//  6. resetn low mid-stream -> stage_valid=0 immediately. After release, the first accept retires
//     after 5 cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the in-order pipeline stage chain
package pipe_pkg;

    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int WB  = 4;

    localparam int PIPE_DW = 64;

    // Payload layout when carrying {pc, inst}
    localparam int INST_LSB = 0;
    localparam int PC_LSB   = 32;

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline slot: valid bit plus payload register
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DW = PIPE_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          allowin_i,
    input  logic          prev_to_next_i,
    input  logic          kill_in_i,
    input  logic          kill_self_i,
    input  logic [DW-1:0] prev_data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // kill_in drops the entry arriving from upstream; kill_self drops the one held here
    always_comb begin
        valid_d = valid_q & ~kill_self_i;
        data_d  = data_q;
        if (allowin_i) begin
            valid_d = prev_to_next_i & ~kill_in_i;
            if (prev_to_next_i) begin
                data_d = prev_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - N-stage valid/allowin pipeline with stall and flush (perf counters under PIPE_PERF_CNT_EN)
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int STAGES = 5,
    parameter int DW     = PIPE_DW
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic [STAGES-1:0]    stage_ready_go,
    input  logic [STAGES-1:0]    flush_req,
    output logic [STAGES-1:0]    stage_valid,
    output logic [STAGES*DW-1:0] stage_data,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    logic [STAGES:0]      allowin;
    logic [STAGES-1:0]    to_next;
    logic [STAGES-1:0]    kill_vec;
    logic                 kill_in;
    logic [STAGES-1:0]    src_to_next;
    logic [STAGES-1:0]    src_kill;
    logic [STAGES*DW-1:0] src_data;

    assign to_next = stage_valid & stage_ready_go;

    // Back-pressure ripples from the downstream consumer toward the youngest stage
    always_comb begin
        allowin         = '0;
        allowin[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            allowin[i] = ~stage_valid[i] | (stage_ready_go[i] & allowin[i+1]);
        end
    end

    // kill_vec[j] is set when any stage older than j redirects
    always_comb begin
        logic acc;
        acc      = 1'b0;
        kill_vec = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            kill_vec[j] = acc;
            acc         = acc | flush_req[j];
        end
    end

    assign kill_in = |flush_req;

    assign src_to_next = {to_next[STAGES-2:0], in_valid};
    assign src_kill    = {kill_vec[STAGES-2:0], kill_in};
    assign src_data    = {stage_data[(STAGES-1)*DW-1:0], in_data};

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        pipe_stage_reg #(.DW(DW)) u_stage (
            .clk            (clk),
            .resetn         (resetn),
            .allowin_i      (allowin[j]),
            .prev_to_next_i (src_to_next[j]),
            .kill_in_i      (src_kill[j]),
            .kill_self_i    (kill_vec[j]),
            .prev_data_i    (src_data[j*DW +: DW]),
            .valid_o        (stage_valid[j]),
            .data_o         (stage_data[j*DW +: DW])
        );
    end

    assign in_ready  = allowin[0];
    assign out_valid = to_next[STAGES-1];
    assign out_data  = stage_data[(STAGES-1)*DW +: DW];

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // An entry at stage j is lost whenever kill_vec[j] is set, whether it moves or holds
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(in_valid & ~in_ready);
        flush_cnt_d = flush_cnt_q + 32'(in_valid & in_ready & kill_in);
        for (int j = 0; j < STAGES; j++) begin
            flush_cnt_d = flush_cnt_d + 32'(stage_valid[j] & kill_vec[j]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed bench for pipe_stage_chain
module tb_pipe_stage_chain;

    localparam int S  = 5;
    localparam int DW = 64;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [S-1:0]  stage_ready_go;
    logic [S-1:0]  flush_req;
    logic [S-1:0]  stage_valid;
    logic [S*DW-1:0] stage_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_flush_cnt;
`endif

    int vectors;
    int miscompares;

    pipe_stage_chain #(.STAGES(S), .DW(DW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .stage_ready_go (stage_ready_go),
        .flush_req      (flush_req),
        .stage_valid    (stage_valid),
        .stage_data     (stage_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [63:0] ed);
        chk({tag, ".valid"}, 64'(out_valid), 64'(ev));
        if (ev) chk({tag, ".data"}, out_data, ed);
    endtask

    function automatic logic [63:0] sdata(input int i);
        return stage_data[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [63:0] base);
        for (int i = 0; i < S; i++) begin
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    logic        exp_v [6];
    logic [63:0] exp_d [6];

    initial begin
        vectors        = 0;
        miscompares    = 0;
        resetn         = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        stage_ready_go = '1;
        flush_req      = '0;
        out_ready      = 1'b1;

        // Reset state
        #1;
        chk("rst.stage_valid", 64'(stage_valid), 64'h0);
        chk("rst.stage_data0", sdata(0), 64'h0);
        chk("rst.stage_data4", sdata(4), 64'h0);
        chk("rst.in_ready", 64'(in_ready), 64'h1);
        chk("rst.out_valid", 64'(out_valid), 64'h0);
`ifdef PIPE_PERF_CNT_EN
        chk("rst.stall_cnt", perf_stall_cnt, 64'h0);
        chk("rst.flush_cnt", perf_flush_cnt, 64'h0);
`endif
        tick();
        tick();
        resetn = 1'b1;

        // 1: stream 1..8, first retirement 5 cycles after first accept
        for (int k = 0; k < 13; k++) begin
            in_valid = (k < 8);
            in_data  = 64'(k + 1);
            #1;
            chk("t1.in_ready", 64'(in_ready), 64'h1);
            chk_out("t1.out", (k >= 5), 64'(k - 4));
            if (k == 5) chk("t1.full", 64'(stage_valid), 64'h1f);
            tick();
        end
        in_valid = 1'b0;

        // 2: stall stage 2 for three cycles on a full pipe
        fill(64'h11);
        chk("t2.full", 64'(stage_valid), 64'h1f);
        chk("t2.s2", sdata(2), 64'h13);
        stage_ready_go = 5'b11011;
        in_valid       = 1'b1;
        in_data        = 64'h16;
        #1;
        chk("t2.c0.in_ready", 64'(in_ready), 64'h0);
        chk_out("t2.c0", 1'b1, 64'h11);
        tick();
        chk("t2.c0.valid", 64'(stage_valid), 64'h17);
        chk("t2.c0.s2", sdata(2), 64'h13);
        chk("t2.c0.s4", sdata(4), 64'h12);
        chk("t2.c1.in_ready", 64'(in_ready), 64'h0);
        chk_out("t2.c1", 1'b1, 64'h12);
        tick();
        chk("t2.c1.valid", 64'(stage_valid), 64'h07);
        chk("t2.c2.in_ready", 64'(in_ready), 64'h0);
        chk_out("t2.c2", 1'b0, 64'h0);
        tick();
        chk("t2.c2.valid", 64'(stage_valid), 64'h07);
        chk("t2.c2.s0", sdata(0), 64'h15);
`ifdef PIPE_PERF_CNT_EN
        chk("t2.stall_cnt", perf_stall_cnt, 64'd3);
`endif
        stage_ready_go = '1;
        #1;
        chk("t2.rel.in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d = '{64'h0, 64'h13, 64'h14, 64'h15, 64'h16, 64'h0};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk_out("t2.drain", exp_v[k], exp_d[k]);
            tick();
        end

        // 3: flush from stage 2 kills stages 0,1 and the accepted input
        fill(64'h21);
        flush_req = 5'b00100;
        in_valid  = 1'b1;
        in_data   = 64'h26;
        #1;
        chk("t3.in_ready", 64'(in_ready), 64'h1);
        chk_out("t3.c0", 1'b1, 64'h21);
        tick();
        flush_req = '0;
        in_valid  = 1'b0;
        chk("t3.valid", 64'(stage_valid), 64'h18);
        chk_out("t3.c1", 1'b1, 64'h22);
        tick();
        chk_out("t3.c2", 1'b1, 64'h23);
        tick();
        chk_out("t3.c3", 1'b0, 64'h0);
        chk("t3.empty", 64'(stage_valid), 64'h0);
`ifdef PIPE_PERF_CNT_EN
        chk("t3.flush_cnt", perf_flush_cnt, 64'd3);
`endif

        // 4: flushes from stages 1 and 3 together; stage 3 entry survives
        fill(64'h31);
        flush_req = 5'b01010;
        in_valid  = 1'b1;
        in_data   = 64'h36;
        #1;
        chk_out("t4.c0", 1'b1, 64'h31);
        tick();
        flush_req = '0;
        in_valid  = 1'b0;
        chk("t4.valid", 64'(stage_valid), 64'h10);
        chk_out("t4.c1", 1'b1, 64'h32);
        tick();
        chk_out("t4.c2", 1'b0, 64'h0);
`ifdef PIPE_PERF_CNT_EN
        chk("t4.flush_cnt", perf_flush_cnt, 64'd7);
`endif

        // 5: downstream back-pressure fills the pipe, nothing lost or duplicated
        in_valid = 1'b1;
        in_data  = 64'h41;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data = 64'h42 + 64'(k);
            #1;
            chk("t5.fill.in_ready", 64'(in_ready), 64'h1);
            tick();
        end
        chk("t5.full", 64'(stage_valid), 64'h1f);
        in_data = 64'h46;
        #1;
        chk("t5.blk.in_ready", 64'(in_ready), 64'h0);
        chk_out("t5.blk", 1'b1, 64'h41);
        tick();
        chk("t5.still_full", 64'(stage_valid), 64'h1f);
        chk("t5.s0", sdata(0), 64'h45);
`ifdef PIPE_PERF_CNT_EN
        chk("t5.stall_cnt", perf_stall_cnt, 64'd4);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d = '{64'h41, 64'h42, 64'h43, 64'h44, 64'h45, 64'h0};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk_out("t5.drain", exp_v[k], exp_d[k]);
            tick();
        end

        // 6: reset mid-stream clears everything immediately
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 64'h51 + 64'(k);
            tick();
        end
        in_valid = 1'b0;
        chk("t6.pre", 64'(stage_valid), 64'h07);
        resetn = 1'b0;
        #1;
        chk("t6.valid", 64'(stage_valid), 64'h0);
        chk("t6.s1", sdata(1), 64'h0);
        chk("t6.in_ready", 64'(in_ready), 64'h1);
        chk_out("t6.rst", 1'b0, 64'h0);
`ifdef PIPE_PERF_CNT_EN
        chk("t6.stall_cnt", perf_stall_cnt, 64'h0);
        chk("t6.flush_cnt", perf_flush_cnt, 64'h0);
`endif
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k == 0);
            in_data  = 64'h61;
            #1;
            if (k == 0) chk("t6.accept", 64'(in_ready), 64'h1);
            chk_out("t6.lat", (k == 5), 64'h61);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
